// File: rtl/oam_dma.sv
// Sprite-attribute DMA: a CPU write to DMA_REG_ADDR halts the CPU and copies 256 bytes
// from page {wdata,8'h00} to OAM_DATA_ADDR. Optional macro OAM_DMA_ODD_ALIGN_EN adds an alignment cycle on odd starts.
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wn,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_rdy,
    output logic        o_dma_own,
    output logic [15:0] o_bus_addr,
    output logic        o_bus_wn,
    output logic [7:0]  o_bus_wdata,
    input  logic [7:0]  i_bus_rdata,
    output logic        o_dma_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] dbuf;
    logic       trigger;
    logic       align_done;

    assign trigger = (i_cpu_addr == DMA_REG_ADDR) && !i_cpu_wn;

`ifdef OAM_DMA_ODD_ALIGN_EN
    logic par;
    logic align_ext;

    // An odd-cycle start holds ALIGN for one extra cycle so reads land on even cycles.
    always_ff @(posedge i_cpu_clk) begin
        if (!i_cpu_rstn) begin
            par       <= 1'b0;
            align_ext <= 1'b0;
        end else begin
            par <= ~par;
            if (state == IDLE && trigger)
                align_ext <= par;
            else if (state == ALIGN)
                align_ext <= 1'b0;
        end
    end

    assign align_done = !align_ext;
`else
    assign align_done = 1'b1;
`endif

    // The write data bus carries dbuf only while a write is being driven.
    assign o_bus_wdata = o_bus_wn ? 8'h00 : dbuf;

    // NOTE: all state and outputs update with non-blocking assignments so every register
    // sees the pre-edge values of the others, which keeps the registered outputs aligned with state.
    always_ff @(posedge i_cpu_clk) begin
        if (!i_cpu_rstn) begin
            state      <= IDLE;
            page       <= 8'h00;
            cnt        <= 8'h00;
            dbuf       <= 8'h00;
            o_cpu_rdy  <= 1'b1;
            o_dma_own  <= 1'b0;
            o_dma_busy <= 1'b0;
            o_bus_addr <= 16'h0000;
            o_bus_wn   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page       <= i_cpu_wdata;
                        cnt        <= 8'h00;
                        state      <= ALIGN;
                        o_cpu_rdy  <= 1'b0;
                        o_dma_busy <= 1'b1;
                    end
                end
                ALIGN: begin
                    if (align_done) begin
                        state      <= READ;
                        o_dma_own  <= 1'b1;
                        o_bus_addr <= {page, cnt};
                        o_bus_wn   <= 1'b1;
                    end
                end
                READ: begin
                    dbuf       <= i_bus_rdata;
                    state      <= WRITE;
                    o_bus_addr <= OAM_DATA_ADDR;
                    o_bus_wn   <= 1'b0;
                end
                WRITE: begin
                    cnt <= cnt + 8'h01;
                    if (cnt == 8'hFF) begin
                        state      <= IDLE;
                        o_cpu_rdy  <= 1'b1;
                        o_dma_busy <= 1'b0;
                        o_dma_own  <= 1'b0;
                        o_bus_addr <= 16'h0000;
                        o_bus_wn   <= 1'b1;
                    end else begin
                        state      <= READ;
                        o_bus_addr <= {page, cnt + 8'h01};
                        o_bus_wn   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG_ADDR, default 16'h4014, meaning CPU write address that starts a transfer.
REQ-002 Parameter OAM_DATA_ADDR, default 16'h2004, meaning PPU OAMDATA address targeted by every DMA write.
REQ-003 i_cpu_clk  input  1  single clock for all logic.
REQ-004 i_cpu_rstn  input  1  reset, synchronous, active-low.
REQ-005 i_cpu_addr  input  16  CPU-driven bus address.
REQ-006 i_cpu_wn  input  1  CPU write strobe, 0 = write.
REQ-007 i_cpu_wdata  input  8  CPU write data.
REQ-008 o_cpu_rdy  output  1  1 = CPU runs; 0 = CPU halted, holds its state.
REQ-009 o_dma_own  output  1  1 = bus mux selects the DMA's o_bus_* in place of the CPU's signals.
REQ-010 o_bus_addr  output  16  DMA bus address.
REQ-011 o_bus_wn  output  1  DMA write strobe, 0 = write.
REQ-012 o_bus_wdata  output  8  DMA write data.
REQ-013 i_bus_rdata  input  8  shared bus read data, valid combinationally in the read cycle.
REQ-014 o_dma_busy  output  1  1 from the cycle after the trigger through the last write cycle.

Function
REQ-015 Trigger: the block SHALL start a transfer in the cycle when i_cpu_addr==DMA_REG_ADDR and i_cpu_wn==0 and state is IDLE.
REQ-016 On trigger, the block SHALL latch page<=i_cpu_wdata, clear the 8-bit byte counter cnt, and enter ALIGN on the next edge.
REQ-017 States SHALL be IDLE, ALIGN, READ, WRITE.
- Every state except IDLE drives o_cpu_rdy=0 and o_dma_busy=1.
- o_dma_own=1 only in READ and WRITE.
REQ-018 A free-running parity bit par SHALL toggle every cycle; reset value is 0.
REQ-019 ALIGN SHALL last 1 cycle; it is extended by one cycle as defined in REQ-030.
REQ-020 READ SHALL drive o_bus_addr={page,cnt} with o_bus_wn=1, capture i_bus_rdata into dbuf at the edge, then go to WRITE.
REQ-021 WRITE SHALL drive o_bus_addr=OAM_DATA_ADDR, o_bus_wn=0 and o_bus_wdata=dbuf.
REQ-022 At the end of WRITE, cnt SHALL increment modulo 256.
- If cnt was 8'hFF, next state is IDLE.
- Otherwise next state is READ.
REQ-023 A transfer SHALL be exactly 256 READ/WRITE pairs, with addresses {page,8'h00}..{page,8'hFF} in ascending order.
REQ-024 Total halt time SHALL be 513 cycles; with the option in REQ-030 active on an odd start, it is 514 cycles.
REQ-025 o_cpu_rdy SHALL return to 1 in the cycle after the last WRITE.
REQ-026 Writes to DMA_REG_ADDR while busy SHALL be ignored: page, cnt and state are unchanged.
REQ-027 When not owning the bus, the block SHALL drive o_bus_wn=1, o_bus_addr=16'h0000 and o_bus_wdata=8'h00.
REQ-028 Page 8'h20 (PPU space) SHALL be transferred without special-casing.

Reset
REQ-029 While i_cpu_rstn==0 at a clock edge, the block SHALL set:
- state = IDLE, cnt = 0, page = 0, dbuf = 0, par = 0;
- o_cpu_rdy = 1, o_dma_own = 0, o_dma_busy = 0, o_bus_wn = 1.
- A reset asserted mid-transfer aborts the transfer; no further OAM write occurs.

Configuration
REQ-030 Macro OAM_DMA_ODD_ALIGN_EN:
- Defined: if par==1 in the trigger cycle, ALIGN SHALL last 2 cycles.
- Undefined: ALIGN SHALL always last 1 cycle and par logic may be removed.

Verification
REQ-031 Even start: write 8'h02 to 16'h4014 at par=0, with memory 16'h0200+i holding i^8'h5A.
- OAM write k carries k^8'h5A.
- o_cpu_rdy=0 for exactly 513 cycles.
REQ-032 Odd start with OAM_DMA_ODD_ALIGN_EN: same stimulus at par=1.
- Halt lasts 514 cycles; the first READ address is 16'h0200.
- Without the macro, the halt is 513 cycles.
REQ-033 Re-trigger: write 8'h07 to 16'h4014 at cycle 100 of a page-8'h03 transfer.
- All 256 reads stay within 16'h0300-16'h03FF; no second transfer starts.
REQ-034 Wrap: page 8'hFF transfer.
- Last READ address is 16'hFFFF, cnt wraps to 0, state returns to IDLE.
- o_dma_own=0 the next cycle.
REQ-035 Reset mid-op: assert i_cpu_rstn=0 for one edge after 40 writes.
- Next cycle: o_cpu_rdy=1, o_dma_busy=0, o_bus_wn=1; no writes to 16'h2004 follow.
REQ-036 Back-to-back: trigger a new transfer one cycle after o_dma_busy falls.
- It SHALL be accepted and complete 256 writes.
